// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives a/b/c/d through every vector, waits SETTLE_CYCLES,
// samples f/g/h against golden gate functions and accumulates a pass/fail result.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [1:0] mode_i,
  input  logic       f_i,
  input  logic       g_i,
  input  logic       h_i,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       d_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [4:0] err_count_o,
  output logic [3:0] first_fail_idx_o,
  output logic [2:0] fail_mask_o
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [1:0] mode_q;
  logic [3:0] idx_q;
  logic [3:0] cnt_q;
  logic [3:0] vec_q;            // {a,b,c,d}
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [4:0] err_q;
  logic [3:0] ffi_q;
  logic [2:0] mask_q;

  logic       exp_f_s, exp_g_s, exp_h_s;
  logic [2:0] chk_mask_s;
  logic [2:0] mism_s;
  logic [3:0] last_idx_s;
  logic [3:0] idx_d;
  logic [3:0] vec_d;

  // Unused inputs are forced low so the narrower DUTs see a clean bus.
  function automatic logic [3:0] map_vec(input logic [1:0] m, input logic [3:0] i);
    case (m)
      2'd0:    map_vec = {i[1], i[0], 1'b0, 1'b0};
      2'd1:    map_vec = {i[2], i[1], i[0], 1'b0};
      default: map_vec = i;
    endcase
  endfunction

  assign exp_f_s = vec_q[3] ^ vec_q[2];
  assign exp_g_s = (vec_q[3] & vec_q[1]) | (vec_q[2] & ~vec_q[1]) | (vec_q[3] & vec_q[2]);
  assign exp_h_s = vec_q[0] | (vec_q[1] & ~(vec_q[3] & vec_q[2]));

  always_comb begin
    chk_mask_s = 3'b000;
    last_idx_s = 4'd15;
    case (mode_q)
      2'd0:    begin chk_mask_s = 3'b001; last_idx_s = 4'd3;  end
      2'd1:    begin chk_mask_s = 3'b010; last_idx_s = 4'd7;  end
      2'd2:    begin chk_mask_s = 3'b100; last_idx_s = 4'd15; end
      default: begin chk_mask_s = 3'b111; last_idx_s = 4'd15; end
    endcase
  end

  assign mism_s = ({h_i, g_i, f_i} ^ {exp_h_s, exp_g_s, exp_f_s}) & chk_mask_s;
  assign idx_d  = idx_q + 4'd1;
  assign vec_d  = map_vec(mode_q, idx_d);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mode_q  <= 2'd0;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
      vec_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 5'd0;
      ffi_q   <= 4'd0;
      mask_q  <= 3'b000;
    end else if (abort_i) begin
      state_q <= IDLE;
      vec_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q <= SETTLE;
            mode_q  <= mode_i;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            vec_q   <= map_vec(mode_i, 4'd0);
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 5'd0;
            ffi_q   <= 4'd0;
            mask_q  <= 3'b000;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        SAMPLE: begin
          if (mism_s != 3'b000) begin
            if (err_q != 5'd16) begin
              err_q <= err_q + 5'd1;
            end
            if (err_q == 5'd0) begin
              ffi_q <= idx_q;
            end
            mask_q <= mask_q | mism_s;
          end
          if (idx_q == last_idx_s) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_q == 5'd0) && (mism_s == 3'b000);
          end else begin
            state_q <= SETTLE;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            cnt_q   <= 4'd0;
          end
        end
        default: begin
          state_q <= IDLE;
          vec_q   <= 4'd0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign {a_o, b_o, c_o, d_o} = vec_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_count_o      = err_q;
  assign first_fail_idx_o = ffi_q;
  assign fail_mask_o      = mask_q;

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Self-checking stimulus/response stage for the lab's combinational gate-level blocks (XOR, 3-input sum-of-products, 4-input AND/OR/NOR network). It drives the shared `a`, `b`, `c`, `d` input bus through a full truth-table sweep. It waits a programmable settle time, samples the DUT outputs `f`, `g`, `h`, and compares them against internally computed golden values. It accumulates a pass/fail result, replacing hand-stepped `#1` stimulus and `$monitor` inspection.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range 1–15.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a sweep; sampled only in IDLE or DONE.
- `abort` input 1: terminate the sweep and return to IDLE; `done` is not set.
- `mode` input 2: 0 = 2-input sweep checking `f`; 1 = 3-input sweep checking `g`; 2 = 4-input sweep checking `h`; 3 = 4-input sweep checking `f`, `g` and `h`. Latched on start.
- `f`, `g`, `h` input 1 each: DUT outputs under test.
- `a`, `b`, `c`, `d` output 1 each: registered stimulus vector.
- `busy` output 1: high in SETTLE and SAMPLE.
- `done` output 1: high in DONE; held until `start`, `abort` or `rst`.
- `pass` output 1: valid while `done` is high; 1 means `err_count` is 0.
- `err_count` output 5: number of vectors with at least one mismatch, range 0–16.
- `first_fail_idx` output 4: index of the first failing vector; 0 when no failure has occurred.
- `fail_mask` output 3: sticky mismatch flags `{h,g,f}`.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Transitions:
  - IDLE/DONE –`start`→ SETTLE. At this edge: index←0, settle counter←0, counters and flags cleared, `mode` latched.
  - SETTLE → SAMPLE once the settle counter reaches `SETTLE_CYCLES`−1.
  - SAMPLE → SETTLE with index+1 if the index is not the last one; otherwise SAMPLE → DONE.
  - Any state –`abort`→ IDLE. `abort` has priority over `start`.
- Vector count: 4 for mode 0, 8 for mode 1, 16 for modes 2 and 3. The last index is count−1; the index never wraps.
- Vector mapping:
  - Mode 0: `a`=idx[1], `b`=idx[0]; `c` and `d` driven 0.
  - Mode 1: `a`=idx[2], `b`=idx[1], `c`=idx[0]; `d` driven 0.
  - Modes 2 and 3: `a`=idx[3], `b`=idx[2], `c`=idx[1], `d`=idx[0].
- The vector register updates on the same edge that enters SETTLE and is constant through the following SAMPLE.
- Golden values, computed from the registered vector:
  - exp_f = a ^ b
  - exp_g = (a & c) | (b & ~c) | (a & b)
  - exp_h = d | (c & ~(a & b))
- Check in SAMPLE: compare only the outputs selected by the latched mode.
  - On any mismatch: `err_count` increments once for the vector; the matching `fail_mask` bits are set.
  - If this is the first failure, `first_fail_idx` ← idx.
- `err_count` saturates at 16 and cannot overflow, because it counts at most one increment per vector.
- `start` while in SETTLE or SAMPLE is ignored.
- In IDLE: `a`–`d` are held at 0. In DONE: the last vector is held.

## Timing
- Reset values: `a`=`b`=`c`=`d`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail_idx`=0, `fail_mask`=0; state IDLE.
- Reset mid-sweep behaves identically to power-on reset; no partial result survives.
- Each vector occupies `SETTLE_CYCLES`+1 cycles.
  - The DUT input is stable for `SETTLE_CYCLES` edges before the sample edge.
- Sweep latency from the `start` edge to `done`=1 is count×(`SETTLE_CYCLES`+1) cycles.
  - Mode 2 with `SETTLE_CYCLES`=2: 48 cycles.
- `pass`, `err_count`, `first_fail_idx` and `fail_mask` are final on the edge that asserts `done`.
- `start` and `abort` asserted in the same cycle: `abort` wins, and the block ends in IDLE.
- `start` asserted in DONE: `done` deasserts on that edge and the result outputs clear on that same edge.

## Test plan
- Correct DUTs (part1/part3/part5 logic), mode 3, `SETTLE_CYCLES`=2 → `done` at 48 cycles after start, `pass`=1, `err_count`=0, `fail_mask`=000.
- Mode 0 with `f` tied to 0 → `err_count`=2 (idx 1 and 2), `first_fail_idx`=1, `fail_mask`=001. The bench also checks that `c`=`d`=0 throughout the sweep.
- Mode 2 with `h` driven as `d` only → failures at idx 2, 6, 10 (c=1, d=0, ab≠11); `err_count`=3, `first_fail_idx`=2, `fail_mask`=100.
- Mode 1 with `g` inverted → `err_count`=8, `first_fail_idx`=0, `pass`=0. `done` asserts 24 cycles after start.
- `rst` pulsed at cycle 10 of a mode 2 sweep → all outputs at reset values the next cycle. A new `start` then completes the full 48-cycle sweep.
- `start` re-pulsed mid-sweep (ignored; the sweep finishes at the original time). Then `start` and `abort` in the same cycle → IDLE, `done`=0, `a`–`d`=0.
